// File: rtl/io_pkg.sv
// Shared constants for the board I/O path: switch debouncer defaults and
// the split of the 32-bit io_data word between outputs and inputs.
package io_pkg;

  localparam int IO_SW_WIDTH     = 16;
  localparam int IO_TICK_DIV     = 50000;
  localparam int IO_STABLE_TICKS = 8;

  localparam int IO_OUT_LSB = 0;
  localparam int IO_IN_LSB  = 16;

endpackage

// File: rtl/debounce_bit.sv
// One debounced input bit: two-flop synchronizer, tick-based qualification
// counter, accepted level register and registered rise/fall pulses.
module debounce_bit
  import io_pkg::*;
#(
  parameter int STABLE_TICKS = IO_STABLE_TICKS
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic raw,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(STABLE_TICKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // Synchronize, then accept the new level only after enough consecutive
  // mismatching ticks; any agreement with the current level restarts the count.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      rise <= 1'b0;
      fall <= 1'b0;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (tick) begin
        if (cnt == CNT_LAST) begin
          stable <= s2;
          cnt    <= '0;
          rise   <= s2;
          fall   <= ~s2;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/switch_debouncer.sv
// Debounces the raw board switches/buttons into clean levels, one-cycle
// edge pulses and a sticky changed flag that software acknowledges.
module switch_debouncer
  import io_pkg::*;
#(
  parameter int WIDTH        = IO_SW_WIDTH,
  parameter int TICK_DIV     = IO_TICK_DIV,
  parameter int STABLE_TICKS = IO_STABLE_TICKS
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_i,
  input  logic             ack_i,
  output logic [WIDTH-1:0] stable_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic             changed_o
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc;
  logic          tick;

  assign tick = (presc == PRESC_LAST);

  // Free-running sample prescaler shared by every bit; only reset restarts it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_bit (
      .clk    (clk),
      .reset_n(reset_n),
      .tick   (tick),
      .raw    (raw_i[i]),
      .stable (stable_o[i]),
      .rise   (rise_o[i]),
      .fall   (fall_o[i])
    );
  end

  // Sticky change flag: a visible pulse sets it and beats a simultaneous ack.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      changed_o <= 1'b0;
    end else if ((|rise_o) || (|fall_o)) begin
      changed_o <= 1'b1;
    end else if (ack_i) begin
      changed_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_switch_debouncer.sv
// Self-checking bench for switch_debouncer with a short prescaler
// (TICK_DIV=4, STABLE_TICKS=3). Expected pulses are queued when stimulus is
// driven and popped by a monitor when the DUT emits them.
module tb_switch_debouncer;

  logic        clk;
  logic        reset_n;
  logic [15:0] raw_i;
  logic        ack_i;
  logic [15:0] stable_o;
  logic [15:0] rise_o;
  logic [15:0] fall_o;
  logic        changed_o;

  switch_debouncer #(
    .WIDTH(16),
    .TICK_DIV(4),
    .STABLE_TICKS(3)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .raw_i    (raw_i),
    .ack_i    (ack_i),
    .stable_o (stable_o),
    .rise_o   (rise_o),
    .fall_o   (fall_o),
    .changed_o(changed_o)
  );

  typedef struct {
    logic [15:0] rise;
    logic [15:0] fall;
    logic [15:0] stable;
  } exp_t;

  typedef struct {
    logic [15:0] raw;
    logic [15:0] rise;
    logic [15:0] fall;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[5];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulse_cyc = 0;
  int rise5_cnt = 0;
  int fall5_cnt = 0;

  // Free-running clock and edge counter used for latency measurement.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic checkRange(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("[TB] FAIL %s latency actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  // Monitor: every pulse cycle must match the next queued expectation.
  always @(negedge clk) begin
    if (rise_o[5] === 1'b1) rise5_cnt++;
    if (fall_o[5] === 1'b1) fall5_cnt++;
    if (rise_o !== 16'h0 || fall_o !== 16'h0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_pulse rise=%h fall=%h required none", rise_o, fall_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        pulse_cyc = cyc;
        checkOutput("pulse_rise", {16'h0, rise_o}, {16'h0, e.rise});
        checkOutput("pulse_fall", {16'h0, fall_o}, {16'h0, e.fall});
        checkOutput("pulse_stable", {16'h0, stable_o}, {16'h0, e.stable});
      end
    end
  end

  task automatic waitDrain(input string name, input int start, input int lo, input int hi);
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout pulses_outstanding=%0d required 0", name, sb.size());
      sb.delete();
    end else begin
      checkRange(name, pulse_cyc - start, lo, hi);
    end
  endtask

  task automatic applyStimulus(input string name, input logic [15:0] raw_val,
                               input logic [15:0] rise, input logic [15:0] fall,
                               input int lo, input int hi, input bit do_ack);
    int start;
    exp_t e;
    start = cyc;
    raw_i = raw_val;
    e.rise = rise;
    e.fall = fall;
    e.stable = raw_val;
    sb.push_back(e);
    waitDrain(name, start, lo, hi);
    @(negedge clk);
    #1;
    checkOutput({name, "_changed"}, {31'h0, changed_o}, 32'h1);
    checkOutput({name, "_stable"}, {16'h0, stable_o}, {16'h0, raw_val});
    if (do_ack) begin
      ack_i = 1'b1;
      @(negedge clk);
      #1;
      ack_i = 1'b0;
      checkOutput({name, "_acked"}, {31'h0, changed_o}, 32'h0);
    end
  endtask

  initial begin
    exp_t e;
    int start;
    int n;

    vecs[0] = '{raw: 16'h0001, rise: 16'h0001, fall: 16'h0000};
    vecs[1] = '{raw: 16'h00F1, rise: 16'h00F0, fall: 16'h0000};
    vecs[2] = '{raw: 16'h0F0F, rise: 16'h0F0E, fall: 16'h00F0};
    vecs[3] = '{raw: 16'hA5A5, rise: 16'hA0A0, fall: 16'h0A0A};
    vecs[4] = '{raw: 16'h0000, rise: 16'h0000, fall: 16'hA5A5};

    // Reset with all inputs high.
    reset_n = 1'b0;
    raw_i   = 16'hFFFF;
    ack_i   = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    checkOutput("reset_stable", {16'h0, stable_o}, 32'h0);
    checkOutput("reset_rise", {16'h0, rise_o}, 32'h0);
    checkOutput("reset_fall", {16'h0, fall_o}, 32'h0);
    checkOutput("reset_changed", {31'h0, changed_o}, 32'h0);
    start = cyc;
    reset_n = 1'b1;
    e = '{rise: 16'hFFFF, fall: 16'h0000, stable: 16'hFFFF};
    sb.push_back(e);
    waitDrain("reset_release", start, 1, 14);
    @(negedge clk);
    #1;
    checkOutput("reset_rise_single", {16'h0, rise_o}, 32'h0);
    checkOutput("reset_changed_set", {31'h0, changed_o}, 32'h1);
    ack_i = 1'b1;
    @(negedge clk);
    #1;
    ack_i = 1'b0;
    applyStimulus("all_fall", 16'h0000, 16'h0000, 16'hFFFF, 11, 14, 1'b1);

    // Clean steps, including multi-bit simultaneous edges.
    for (int i = 0; i < 5; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].raw, vecs[i].rise, vecs[i].fall, 11, 14, 1'b1);
    end

    // Glitch shorter than the qualification window.
    raw_i = 16'h0008;
    repeat (6) @(negedge clk);
    raw_i = 16'h0000;
    repeat (40) @(negedge clk);
    #1;
    checkOutput("glitch_stable", {16'h0, stable_o}, 32'h0);
    checkOutput("glitch_changed", {31'h0, changed_o}, 32'h0);

    // Bounce every 3 cycles, then settle high.
    rise5_cnt = 0;
    fall5_cnt = 0;
    raw_i = 16'h0020;
    for (int i = 0; i < 10; i++) begin
      repeat (3) @(negedge clk);
      raw_i[5] = ~raw_i[5];
    end
    applyStimulus("bounce", 16'h0020, 16'h0020, 16'h0000, 0, 60, 1'b1);
    repeat (20) @(negedge clk);
    #1;
    checkOutput("bounce_rise_count", rise5_cnt, 32'd1);
    checkOutput("bounce_fall_count", fall5_cnt, 32'd0);

    // Ack colliding with a fall pulse: the set must win.
    applyStimulus("ack_setup", 16'h0024, 16'h0004, 16'h0000, 11, 14, 1'b0);
    raw_i = 16'h0020;
    e = '{rise: 16'h0000, fall: 16'h0004, stable: 16'h0020};
    sb.push_back(e);
    n = 0;
    while (fall_o[2] !== 1'b1 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("ack_collision_seen", {31'h0, fall_o[2]}, 32'h1);
    ack_i = 1'b1;
    @(negedge clk);
    #1;
    ack_i = 1'b0;
    checkOutput("ack_collision_changed", {31'h0, changed_o}, 32'h1);
    ack_i = 1'b1;
    @(negedge clk);
    #1;
    ack_i = 1'b0;
    checkOutput("ack_plain_changed", {31'h0, changed_o}, 32'h0);

    // Reset in the middle of a qualification.
    applyStimulus("clear_bit5", 16'h0000, 16'h0000, 16'h0020, 11, 14, 1'b1);
    raw_i = 16'h0080;
    repeat (8) @(negedge clk);
    reset_n = 1'b0;
    raw_i = 16'h0000;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checkOutput("midreset_stable", {16'h0, stable_o}, 32'h0);
    checkOutput("midreset_changed", {31'h0, changed_o}, 32'h0);
    repeat (40) @(negedge clk);
    #1;
    checkOutput("midreset_stable_end", {16'h0, stable_o}, 32'h0);
    checkOutput("midreset_changed_end", {31'h0, changed_o}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/switch_debouncer.md
# switch_debouncer

Input-side companion to the seven-segment/LED output path on the FPGA top. It takes raw, asynchronous board inputs (slide switches, push buttons) and produces clean, debounced levels for the upper half of `io_data`. It also provides one-cycle rise/fall pulses and a sticky "changed" flag that software or the SoC can poll and acknowledge. It runs entirely in the divided core clock domain.

## Interface
Parameters:
- `WIDTH`, 16: number of input bits.
- `TICK_DIV`, 50000: core-clock cycles per sample tick (1 ms at 50 MHz); must be ≥ 2.
- `STABLE_TICKS`, 8: consecutive mismatching ticks required to accept a new level; must be ≥ 2.

Ports:
- `clk`  in  1: core clock.
- `reset_n`  in  1: synchronous, active-low reset.
- `raw_i`  in  WIDTH: asynchronous board inputs.
- `ack_i`  in  1: clears `changed_o`.
- `stable_o`  out  WIDTH: debounced level.
- `rise_o`  out  WIDTH: one-cycle pulse per bit on a debounced 0→1 transition.
- `fall_o`  out  WIDTH: one-cycle pulse per bit on a debounced 1→0 transition.
- `changed_o`  out  1: sticky; set by any rise or fall.

## Operation
- **Synchronizer:** two flops per bit, `raw_i` → `s1` → `s2`. The `s2` value is the sampled level.
- **Prescaler:**
  - Shared counter `0..TICK_DIV-1`, wraps to 0.
  - `tick` is high in the cycle the counter equals `TICK_DIV-1`.
- **Per-bit counter `cnt`:**
  - Width is `$clog2(STABLE_TICKS)`.
  - If `s2 == stable`: `cnt <= 0` every cycle, regardless of `tick`. Any agreement, even for one cycle, restarts qualification.
  - Else, if `tick` and `cnt == STABLE_TICKS-1`: `stable <= s2`, `cnt <= 0`, and the matching `rise`/`fall` pulse is registered.
  - Else, if `tick`: `cnt <= cnt+1`.
  - Else: `cnt` holds.
- **Pulse alignment:** `rise_o`/`fall_o` are registered and high in the same cycle that `stable_o` first shows the new value. They are low in every other cycle. Multiple bits may pulse in the same cycle.
- **`changed_o` priority:**
  - Any pulse this cycle → 1. Set wins over a simultaneous `ack_i`.
  - Otherwise, `ack_i` → 0.
  - Otherwise, hold.
- **Reset** (`reset_n` low at a `clk` edge): sync flops, prescaler, all `cnt`, `stable_o`, `rise_o`, `fall_o`, and `changed_o` all go to 0.
  - An in-progress qualification is discarded; no pulse is emitted.
  - After reset, inputs already at 1 qualify normally and produce rise pulses. This is intended, so software sees the initial state.

## Timing
- All outputs are registered; there are no combinational paths from `raw_i` or `ack_i` to any output.
- **Latency:** a clean `raw_i` step held steady reaches `stable_o` after 2 sync cycles plus between `(STABLE_TICKS-1)*TICK_DIV+1` and `STABLE_TICKS*TICK_DIV` cycles. The exact value depends on prescaler phase.
- **Short pulses:** a `raw_i` pulse shorter than `(STABLE_TICKS-1)*TICK_DIV` cycles never changes `stable_o`.
- **`ack_i` timing:** takes effect at the next edge, so `changed_o` is 0 the cycle after `ack_i` unless a new pulse coincides.
- **Prescaler:** free-running and never reset by input activity. Only `reset_n` resets it.

## Structure
- **Shared package `io_pkg`:**
  - Default constants `IO_SW_WIDTH = 16`, `IO_TICK_DIV`, and `IO_STABLE_TICKS`.
  - The `io_data` split localparams (`IO_OUT_LSB = 0`, `IO_IN_LSB = 16`), shared with the FPGA top.
- **Sub-modules:**
  - `debounce_bit`: one instance per bit, containing the synchronizer, `cnt`, stable register, and pulse register. It takes `tick` from the parent.
  - Prescaler and `changed_o` logic stay in `switch_debouncer`.
- **Top-level hookup:** the FPGA top drives `io_data[31:16]` from `stable_o` instead of raw `SW`.

## Test plan
All scenarios use `TICK_DIV=4`, `STABLE_TICKS=3` unless noted.
- **Reset:** `raw_i=16'hFFFF` with `reset_n` low for 5 cycles → all outputs 0. After release, `stable_o` reaches `16'hFFFF` within 2+12 cycles, with a single-cycle `rise_o=16'hFFFF` in that same cycle; `changed_o=1`.
- **Clean step:** `raw_i[0]` 0→1 and held → `stable_o[0]` rises between 11 and 14 cycles later (inclusive); exactly one `rise_o[0]` pulse; no `fall_o`.
- **Glitch:** `raw_i[3]` high for 6 cycles, then low → `stable_o`, `rise_o`, `fall_o`, `changed_o` all remain 0 for 40 cycles.
- **Bounce:** `raw_i[5]` toggles every 3 cycles for 30 cycles, then holds 1 → exactly one `rise_o[5]` pulse, zero `fall_o[5]` pulses.
- **Ack collision:** `changed_o=1`, then assert `ack_i` in the same cycle as a `fall_o[2]` pulse → `changed_o` stays 1. Next `ack_i` with no pulse → `changed_o=0` one cycle later.
- **Reset mid-count:** `raw_i[7]` high for 8 cycles, pulse `reset_n` low 1 cycle, drop `raw_i[7]` → no `rise_o[7]`, `stable_o[7]=0` throughout.
